fp_div_arbiter: RTL and testbench

FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

---
 rtl/vector_engine_pkg.sv | 15 +
 rtl/fp_div_arbiter_if.sv | 31 +++
 rtl/fp_div_arbiter_rr_arbiter.sv | 49 ++++
 rtl/fp_div_arbiter.sv | 105 ++++++++++
 tb/tb_fp_div_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_engine_pkg.sv
// Shared vector engine definitions: default sizes for the divider
// arbiter and the helper that sizes requester tags.
package vector_engine_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int SIG_WIDTH_DEF = 23;
    localparam int EXP_WIDTH_DEF = 8;
    localparam int STAGES_DEF    = 5;

    // Bits needed to name one of n requesters (never less than 1).
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_div_arbiter_if.sv
// Request/grant bundle between the divider front end and its arbiter.
// Signals: req (valid per requester), accept (handshake this cycle),
// grant (one-hot), grant_idx (binary index of grant).
interface fp_div_arbiter_if
    import vector_engine_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
);

    localparam int TW = tag_width(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [TW-1:0]      grant_idx;
    logic               accept;

    modport master (
        output req,
        output accept,
        input  grant,
        input  grant_idx
    );

    modport slave (
        input  req,
        input  accept,
        output grant,
        output grant_idx
    );

endinterface

// File: rtl/fp_div_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances
// on accept. Ports: clk, rst_n, bus (request/grant bundle, slave side).
module rr_arbiter
    import vector_engine_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_div_arbiter_if.slave  bus
);

    localparam int TW = tag_width(NUM_REQ);

    logic [TW-1:0]      last_grant;
    logic [NUM_REQ-1:0] grant;
    logic [TW-1:0]      idx;
    logic               found;
    int                 pos;

    // Search starts one past the last winner and wraps around.
    always_comb begin
        grant = '0;
        idx   = last_grant;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = (int'(last_grant) + k) % NUM_REQ;
            if (!found && bus.req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = TW'(pos);
            end
        end
    end

    // Reset value makes requester 0 the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= TW'(NUM_REQ - 1);
        end else if (bus.accept) begin
            last_grant <= idx;
        end
    end

    assign bus.grant     = grant;
    assign bus.grant_idx = idx;

endmodule

// File: rtl/fp_div_arbiter.sv
// Shares one pipelined FP divider among NUM_REQ requesters.
// Ports: clk/rst_n; req_valid/req_a/req_b/req_ready requester side;
// div_a/div_b/div_ab_valid, div_z/div_z_valid divider side;
// rsp_z/rsp_valid one-hot response; tag_err sticky tag mismatch.
module fp_div_arbiter
    import vector_engine_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int SIG_WIDTH = SIG_WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF,
    parameter int STAGES    = STAGES_DEF,
    localparam int W        = SIG_WIDTH + EXP_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [W-1:0]         div_a,
    output logic [W-1:0]         div_b,
    output logic                 div_ab_valid,
    input  logic [W-1:0]         div_z,
    input  logic                 div_z_valid,
    output logic [W-1:0]         rsp_z,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic                 tag_err
);

    localparam int TW = tag_width(NUM_REQ);

    fp_div_arbiter_if #(.NUM_REQ(NUM_REQ)) arb ();

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (arb)
    );

    logic         hs;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;

    assign arb.req    = req_valid;
    assign hs         = |(req_valid & arb.grant);
    assign arb.accept = hs;
    assign req_ready  = arb.grant;
    assign sel_a      = req_a[int'(arb.grant_idx)*W +: W];
    assign sel_b      = req_b[int'(arb.grant_idx)*W +: W];

    // Operand register: the divider sees the winner one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a        <= '0;
            div_b        <= '0;
            div_ab_valid <= 1'b0;
        end else begin
            div_ab_valid <= hs;
            if (hs) begin
                div_a <= sel_a;
                div_b <= sel_b;
            end
        end
    end

    // Entry 0 lines up with div_ab_valid, entry STAGES with div_z_valid.
    logic [STAGES:0] tag_v;
    logic [TW-1:0]   tag_id [STAGES+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i <= STAGES; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= hs;
            tag_id[0] <= arb.grant_idx;
            for (int i = 1; i <= STAGES; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // A quotient without a tag (or a tag without a quotient) is
    // latched as an error and never forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_z     <= '0;
            rsp_valid <= '0;
            tag_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (div_z_valid && tag_v[STAGES]) begin
                rsp_z     <= div_z;
                rsp_valid <= NUM_REQ'(1) << tag_id[STAGES];
            end
            if (div_z_valid != tag_v[STAGES]) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Self-checking bench for fp_div_arbiter with a behavioural divider,
// a round-robin reference model and a response scoreboard.
module tb_fp_div_arbiter;
    import vector_engine_pkg::*;

    localparam int N  = 4;
    localparam int ST = 5;
    localparam int W  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_div_arbiter_if #(.NUM_REQ(N)) ifc ();

    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   div_a, div_b, div_z, rsp_z;
    logic           div_ab_valid, div_z_valid, tag_err;
    logic [N-1:0]   rsp_valid;
    logic           inj = 1'b0;

    fp_div_arbiter #(
        .NUM_REQ(N), .SIG_WIDTH(23), .EXP_WIDTH(8), .STAGES(ST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (ifc.req),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (ifc.grant),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_ab_valid (div_ab_valid),
        .div_z        (div_z),
        .div_z_valid  (div_z_valid),
        .rsp_z        (rsp_z),
        .rsp_valid    (rsp_valid),
        .tag_err      (tag_err)
    );

    assign ifc.accept = |(ifc.req & ifc.grant);
    always_comb begin
        ifc.grant_idx = '0;
        for (int i = 0; i < N; i++)
            if (ifc.grant[i]) ifc.grant_idx = 2'(i);
    end

    // Single-precision divide for normal operands (truncating).
    function automatic logic [31:0] fdiv(input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] q;
        logic [23:0] m;
        int e;
        q = ({40'd0, 1'b1, a[22:0]} << 24) / {40'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q[24]) m = q[24:1];
        else begin
            m = q[23:0];
            e = e - 1;
        end
        return {a[31] ^ b[31], 8'(e), m[22:0]};
    endfunction

    // Stand-in for fp_div_pipe with STAGES cycles of latency.
    logic [ST-1:0] pv;
    logic [W-1:0]  pz [ST];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < ST; i++) pz[i] <= '0;
        end else begin
            pv    <= {pv[ST-2:0], div_ab_valid};
            pz[0] <= fdiv(div_a, div_b);
            for (int i = 1; i < ST; i++) pz[i] <= pz[i-1];
        end
    end
    assign div_z_valid = pv[ST-1] | inj;
    assign div_z       = pz[ST-1];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: every handshake owes one response STAGES+2 later.
    typedef struct {
        int          id;
        logic [31:0] z;
        int          due;
    } exp_t;
    exp_t sbq[$];
    exp_t se;
    int   rsp_cnt[N];

    initial for (int i = 0; i < N; i++) rsp_cnt[i] = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
                se = sbq.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL rsp_missing: req %0d due cycle %0d",
                         se.id, se.due);
            end
            if (rsp_valid != '0) begin
                for (int i = 0; i < N; i++)
                    if (rsp_valid[i]) rsp_cnt[i]++;
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    se = sbq.pop_front();
                    chk("rsp_owner", 64'(rsp_valid), 64'(1) << se.id);
                    chk("rsp_z", 64'(rsp_z), 64'(se.z));
                    chk("rsp_cycle", 64'(cyc), 64'(se.due));
                end
            end
            if (ifc.accept) begin
                se.id  = int'(ifc.grant_idx);
                se.z   = fdiv(req_a[se.id*W +: W], req_b[se.id*W +: W]);
                se.due = cyc + ST + 2;
                sbq.push_back(se);
            end
        end
    end

    // Round-robin reference: first valid requester after the last winner.
    int mlast = N - 1;

    function automatic logic [N-1:0] rr_pred(input logic [N-1:0] v,
                                             input int last);
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (last + k) % N;
            if (v[p]) return N'(1) << p;
        end
        return '0;
    endfunction

    task automatic drive(input logic [N-1:0] v,
                         output logic [N-1:0] rdy,
                         output logic [N-1:0] exp);
        @(posedge clk);
        #1;
        ifc.req = v;
        #1;
        rdy = ifc.grant;
        exp = rr_pred(v, mlast);
        for (int i = 0; i < N; i++)
            if (exp[i]) mlast = i;
    endtask

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(100, 154)),
                23'($urandom)};
    endfunction

    task automatic set_op(input int i);
        req_a[i*W +: W] = rnd_fp();
        req_b[i*W +: W] = rnd_fp();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        ifc.req = '0;
        rst_n = 1'b0;
        mlast = N - 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        logic [N-1:0] r, e;
        for (int k = 0; k < n; k++) drive('0, r, e);
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] r;
    } vec_t;
    vec_t tbl[13];

    logic [N-1:0] rdy, expv, pend;
    int g0, g3, g1, base;

    initial begin
        tbl[0]  = '{4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0100};
        tbl[2]  = '{4'b1111, 4'b1000};
        tbl[3]  = '{4'b0111, 4'b0001};
        tbl[4]  = '{4'b1110, 4'b0010};
        tbl[5]  = '{4'b1100, 4'b0100};
        tbl[6]  = '{4'b1001, 4'b1000};
        tbl[7]  = '{4'b0011, 4'b0001};
        tbl[8]  = '{4'b0010, 4'b0010};
        tbl[9]  = '{4'b0000, 4'b0000};
        tbl[10] = '{4'b1001, 4'b1000};
        tbl[11] = '{4'b0101, 4'b0001};
        tbl[12] = '{4'b0100, 4'b0100};

        ifc.req = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_div_a", 64'(div_a), 64'd0);
        chk("rst_div_b", 64'(div_b), 64'd0);
        chk("rst_div_ab_valid", 64'(div_ab_valid), 64'd0);
        chk("rst_rsp_z", 64'(rsp_z), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_tag_err", 64'(tag_err), 64'd0);
        chk("rst_ready", 64'(ifc.grant), 64'd0);
        rst_n = 1'b1;

        // Arbitration table, requesters never withdraw while pending.
        pend = '0;
        for (int t = 0; t < 13; t++) begin
            for (int i = 0; i < N; i++)
                if (tbl[t].v[i] && !pend[i]) set_op(i);
            drive(tbl[t].v, rdy, expv);
            chk($sformatf("table_%0d", t), 64'(rdy), 64'(tbl[t].r));
            pend = tbl[t].v & ~tbl[t].r;
        end
        idle(ST + 3);

        // Single request: 6.0 / 2.0 from requester 2.
        do_reset();
        req_a[2*W +: W] = 32'h40C00000;
        req_b[2*W +: W] = 32'h40000000;
        drive(4'b0100, rdy, expv);
        chk("single_ready", 64'(rdy), 64'(4'b0100));
        for (int k = 0; k < ST + 2; k++) begin
            drive('0, rdy, expv);
            if (k == 0) begin
                chk("single_ab_valid", 64'(div_ab_valid), 64'd1);
                chk("single_div_a", 64'(div_a), 64'h40C00000);
            end
        end
        chk("single_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        chk("single_rsp_z", 64'(rsp_z), 64'h40400000);
        idle(2);

        // Four simultaneous requests after reset.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i);
        pend = '1;
        for (int k = 0; k < N; k++) begin
            drive(pend, rdy, expv);
            chk($sformatf("order_%0d", k), 64'(rdy), 64'(1) << k);
            pend = pend & ~rdy;
        end
        idle(ST + 3);

        // Fairness between requesters 0 and 3.
        do_reset();
        set_op(0);
        set_op(3);
        g0 = 0;
        g3 = 0;
        for (int k = 0; k < 20; k++) begin
            drive(4'b1001, rdy, expv);
            chk("fair_alt", 64'(rdy),
                (k % 2 == 0) ? 64'(4'b0001) : 64'(4'b1000));
            if (rdy[0]) begin g0++; set_op(0); end
            if (rdy[3]) begin g3++; set_op(3); end
        end
        chk("fair_cnt0", 64'(g0), 64'd10);
        chk("fair_cnt3", 64'(g3), 64'd10);
        ifc.req = '0;
        idle(ST + 3);

        // Streaming from requester 1.
        base = rsp_cnt[1];
        g1 = 0;
        for (int k = 0; k < 16; k++) begin
            set_op(1);
            drive(4'b0010, rdy, expv);
            if (rdy == 4'b0010) g1++;
        end
        idle(ST + 3);
        chk("stream_grants", 64'(g1), 64'd16);
        chk("stream_rsps", 64'(rsp_cnt[1] - base), 64'd16);

        // Random traffic against the round-robin model.
        pend = '0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 99) < 40) begin
                    pend[i] = 1'b1;
                    set_op(i);
                end
            drive(pend, rdy, expv);
            chk("rr_random", 64'(rdy), 64'(expv));
            pend = pend & ~expv;
        end
        ifc.req = '0;
        idle(ST + 3);
        chk("random_tag_err", 64'(tag_err), 64'd0);
        chk("random_drained", 64'(sbq.size()), 64'd0);

        // Reset with three operations in flight.
        do_reset();
        for (int i = 0; i < 3; i++) set_op(i);
        pend = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            drive(pend, rdy, expv);
            chk("flight_grant", 64'(rdy), 64'(1) << k);
            pend = pend & ~rdy;
        end
        @(posedge clk);
        #1;
        ifc.req = '0;
        rst_n = 1'b0;
        mlast = N - 1;
        #1;
        chk("mid_rst_div_a", 64'(div_a), 64'd0);
        chk("mid_rst_div_b", 64'(div_b), 64'd0);
        chk("mid_rst_ab_valid", 64'(div_ab_valid), 64'd0);
        chk("mid_rst_rsp_z", 64'(rsp_z), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_tag_err", 64'(tag_err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2 * ST; k++) begin
            drive('0, rdy, expv);
            chk("post_rst_quiet", 64'(rsp_valid), 64'd0);
        end
        chk("post_rst_tag_err", 64'(tag_err), 64'd0);

        // Quotient valid with no tag in flight.
        @(posedge clk);
        #1;
        inj = 1'b1;
        @(posedge clk);
        #1;
        inj = 1'b0;
        chk("inj_tag_err", 64'(tag_err), 64'd1);
        chk("inj_no_rsp", 64'(rsp_valid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            drive('0, rdy, expv);
            chk("inj_sticky", 64'(tag_err), 64'd1);
            chk("inj_quiet", 64'(rsp_valid), 64'd0);
        end
        chk("final_drained", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
